// File: rtl/mmio_ctrl.sv
// mmio_ctrl: IO-region decode, uart TX/RX byte FIFOs and cycle/instret counters.
module mmio_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        inst_retired,
  output logic [31:0] rd_data,
  output logic [7:0]  uart_data_in,
  output logic        uart_data_in_valid,
  input  logic        uart_data_in_ready,
  input  logic [7:0]  uart_data_out,
  input  logic        uart_data_out_valid,
  output logic        uart_data_out_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0] cnt_t;
  localparam cnt_t FULL = cnt_t'(FIFO_DEPTH);
  logic [7:0] tx_mem_q [FIFO_DEPTH];
  logic [7:0] tx_mem_d [FIFO_DEPTH];
  logic [7:0] rx_mem_q [FIFO_DEPTH];
  logic [7:0] rx_mem_d [FIFO_DEPTH];
  ptr_t tx_rp_q, tx_rp_d, tx_wp_q, tx_wp_d, rx_rp_q, rx_rp_d, rx_wp_q, rx_wp_d;
  cnt_t tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d, inst_q, inst_d;
  logic [31:0] rd_data_q, rd_data_d, rd_val;
  logic [7:0] off;
  logic io_sel, rd, wr, tx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop, clr;
  logic unused_bits;
  assign unused_bits = ^{wr_data[31:8], addr[27:8]};
  assign io_sel = addr[31:28] == 4'h8;
  assign off = addr[7:0];
  assign rd = rd_en && io_sel;
  assign wr = wr_en && io_sel;
  assign tx_full = tx_cnt_q == FULL;
  assign rx_empty = rx_cnt_q == '0;
  assign uart_data_in_valid = tx_cnt_q != '0;
  assign uart_data_out_ready = rx_cnt_q != FULL;
  assign uart_data_in = tx_mem_q[tx_rp_q];
  assign rd_data = rd_data_q;
  // A push into a full FIFO is dropped even if a pop lands on the same edge.
  assign tx_push = wr && off == 8'h08 && !tx_full;
  assign tx_pop = uart_data_in_valid && uart_data_in_ready;
  assign rx_push = uart_data_out_valid && uart_data_out_ready;
  assign rx_pop = rd && off == 8'h04 && !rx_empty;
  assign clr = wr && off == 8'h18;
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push) tx_mem_d[tx_wp_q] = wr_data[7:0];
    if (rx_push) rx_mem_d[rx_wp_q] = uart_data_out;
    tx_wp_d = tx_wp_q + ptr_t'(tx_push);
    tx_rp_d = tx_rp_q + ptr_t'(tx_pop);
    rx_wp_d = rx_wp_q + ptr_t'(rx_push);
    rx_rp_d = rx_rp_q + ptr_t'(rx_pop);
    tx_cnt_d = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
    rx_cnt_d = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
    cyc_d = clr ? '0 : cyc_q + CNT_WIDTH'(1);
    inst_d = clr ? '0 : inst_q + CNT_WIDTH'(inst_retired);
    rd_val = off == 8'h00 ? {30'd0, !rx_empty, !tx_full} :
             off == 8'h04 ? {24'd0, rx_empty ? 8'd0 : rx_mem_q[rx_rp_q]} :
             off == 8'h10 ? 32'(cyc_q) :
             off == 8'h14 ? 32'(inst_q) : 32'd0;
    rd_data_d = rd ? rd_val : rd_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_mem_q <= '{default: '0};
      rx_mem_q <= '{default: '0};
      tx_rp_q <= '0;
      tx_wp_q <= '0;
      rx_rp_q <= '0;
      rx_wp_q <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      cyc_q <= '0;
      inst_q <= '0;
      rd_data_q <= '0;
    end else begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
      tx_rp_q <= tx_rp_d;
      tx_wp_q <= tx_wp_d;
      rx_rp_q <= rx_rp_d;
      rx_wp_q <= rx_wp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      cyc_q <= cyc_d;
      inst_q <= inst_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed checks of mmio_ctrl decode, FIFOs, counters and reset.
module tb_mmio_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] addr = '0, wr_data = '0, rd_data;
  logic wr_en = 1'b0, rd_en = 1'b0, inst_retired = 1'b0;
  logic [7:0] uart_data_in, uart_data_out = '0;
  logic uart_data_in_valid, uart_data_in_ready = 1'b0;
  logic uart_data_out_valid = 1'b0, uart_data_out_ready;
  int n_chk = 0, n_fail = 0;
  logic [31:0] d;
  mmio_ctrl dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .wr_en(wr_en),
    .rd_en(rd_en), .inst_retired(inst_retired), .rd_data(rd_data),
    .uart_data_in(uart_data_in), .uart_data_in_valid(uart_data_in_valid),
    .uart_data_in_ready(uart_data_in_ready), .uart_data_out(uart_data_out),
    .uart_data_out_valid(uart_data_out_valid), .uart_data_out_ready(uart_data_out_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic io_rd(input logic [31:0] a, output logic [31:0] r);
    addr = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    r = rd_data;
  endtask
  task automatic io_wr(input logic [7:0] off, input logic [7:0] v);
    addr = {24'h800000, off};
    wr_data = {24'hFFFFFF, v};
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_tx_valid", {31'd0, uart_data_in_valid}, 32'h0);
    check("rst_rx_ready", {31'd0, uart_data_out_ready}, 32'h1);
    check("rst_tx_head", {24'd0, uart_data_in}, 32'h0);
    rst = 1'b0;
    io_rd(32'h8000_0000, d); check("status_idle", d, 32'h1);
    io_rd(32'h8000_000C, d); check("unmapped_rd", d, 32'h0);
    io_rd(32'h8000_0000, d);
    io_rd(32'h0000_0010, d); check("non_io_hold", d, 32'h1);
    // TX fill to full with uart stalled, then drain
    for (int i = 0; i < 8; i++) io_wr(8'h08, 8'(8'h41 + i));
    io_rd(32'h8000_0000, d); check("status_tx_full", d, 32'h0);
    io_wr(8'h08, 8'h49);
    uart_data_in_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tx_drain_valid", {31'd0, uart_data_in_valid}, 32'h1);
      check("tx_drain_byte", {24'd0, uart_data_in}, 32'(8'h41 + i));
      @(negedge clk);
    end
    check("tx_empty_valid", {31'd0, uart_data_in_valid}, 32'h0);
    uart_data_in_ready = 1'b0;
    // RX inject and pop
    uart_data_out_valid = 1'b1;
    uart_data_out = 8'h5A;
    @(negedge clk);
    uart_data_out = 8'hA5;
    @(negedge clk);
    uart_data_out_valid = 1'b0;
    io_rd(32'h8000_0000, d); check("status_rx", d, 32'h3);
    io_rd(32'h8000_0004, d); check("rx_pop0", d, 32'h5A);
    io_rd(32'h8000_0004, d); check("rx_pop1", d, 32'hA5);
    io_rd(32'h8000_0004, d); check("rx_empty_rd", d, 32'h0);
    io_rd(32'h8000_0000, d); check("status_rx_empty", d, 32'h1);
    // RX at count 3 with simultaneous push/pop across pointer wrap
    uart_data_out_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      uart_data_out = 8'(8'h10 + i);
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      addr = 32'h8000_0004;
      rd_en = 1'b1;
      uart_data_out = 8'(8'h13 + k);
      @(negedge clk);
      check("rx_pushpop", rd_data, 32'(8'h10 + k));
      check("rx_ready_held", {31'd0, uart_data_out_ready}, 32'h1);
    end
    rd_en = 1'b0;
    uart_data_out_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io_rd(32'h8000_0004, d); check("rx_drain", d, 32'(8'h18 + i));
    end
    io_rd(32'h8000_0004, d); check("rx_drained", d, 32'h0);
    // counters: 100 cycles after clear with 37 retires
    io_wr(8'h18, 8'h00);
    for (int i = 0; i < 100; i++) begin
      inst_retired = i < 37;
      @(negedge clk);
    end
    inst_retired = 1'b0;
    io_rd(32'h8000_0014, d); check("instret_37", d, 32'd37);
    io_rd(32'h8000_0010, d); check("cycle_101", d, 32'd101);
    inst_retired = 1'b1;
    io_wr(8'h18, 8'h00);
    inst_retired = 1'b0;
    io_rd(32'h8000_0010, d); check("cycle_clr", d, 32'h0);
    io_rd(32'h8000_0014, d); check("instret_clr", d, 32'h0);
    // asynchronous reset with bytes queued in both FIFOs
    for (int i = 0; i < 5; i++) io_wr(8'h08, 8'(8'h61 + i));
    uart_data_out = 8'h77;
    uart_data_out_valid = 1'b1;
    @(negedge clk);
    uart_data_out_valid = 1'b0;
    io_rd(32'h8000_0000, d); check("status_pre_rst", d, 32'h3);
    check("tx_valid_pre_rst", {31'd0, uart_data_in_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_tx_valid", {31'd0, uart_data_in_valid}, 32'h0);
    check("async_tx_head", {24'd0, uart_data_in}, 32'h0);
    check("async_rd_data", rd_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    io_rd(32'h8000_0010, d); check("post_rst_cycle", d, 32'h0);
    io_rd(32'h8000_0014, d); check("post_rst_instret", d, 32'h0);
    io_rd(32'h8000_0000, d); check("post_rst_status", d, 32'h1);
    io_rd(32'h8000_0004, d); check("post_rst_rx", d, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
